// File: rtl/alu_issue_pkg.sv
// Shared constants for alu_issue: instruction field positions, opcode encodings,
// issue FSM state type and the supported-opcode decode.
package alu_issue_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_NUM = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned OP_W    = 6;

  localparam int unsigned OP_HI   = 31;
  localparam int unsigned OP_LO   = 26;
  localparam int unsigned RD_HI   = 25;
  localparam int unsigned RD_LO   = 21;
  localparam int unsigned RS_HI   = 20;
  localparam int unsigned RS_LO   = 16;
  localparam int unsigned RT_HI   = 15;
  localparam int unsigned RT_LO   = 11;
  localparam int unsigned IMM_BIT = 10;
  localparam int unsigned IMM_W   = 10;

  localparam logic [OP_W-1:0] OP_ADD = 6'b010000;
  localparam logic [OP_W-1:0] OP_OR  = 6'b010001;
  localparam logic [OP_W-1:0] OP_NOR = 6'b010010;
  localparam logic [OP_W-1:0] OP_XOR = 6'b010011;
  localparam logic [OP_W-1:0] OP_RLS = 6'b001100;
  localparam logic [OP_W-1:0] OP_LLS = 6'b001101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WB
  } state_e;

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_ADD, OP_OR, OP_NOR, OP_XOR, OP_RLS, OP_LLS: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 32x32 register file for alu_issue: two operand read ports, a debug read tap,
// and one write port shared between writeback and the debug preload path.
module alu_issue_regfile
  import alu_issue_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dbg_we_i,
  input  logic [REG_AW-1:0] dbg_addr_i,
  input  logic [XLEN-1:0]   dbg_data_i,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [XLEN-1:0]   wb_data_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  output logic [XLEN-1:0]   rs_data_o,
  input  logic [REG_AW-1:0] rt_addr_i,
  output logic [XLEN-1:0]   rt_data_o,
  input  logic [REG_AW-1:0] dbg_rd_addr_i,
  output logic [XLEN-1:0]   dbg_rd_data_o
);

  logic [XLEN-1:0]   mem_q [REG_NUM];
  logic              we_d;
  logic [REG_AW-1:0] waddr_d;
  logic [XLEN-1:0]   wdata_d;

  // Writeback and debug writes are never enabled together (debug is gated to IDLE).
  always_comb begin
    we_d    = wb_we_i | dbg_we_i;
    waddr_d = wb_we_i ? wb_addr_i : dbg_addr_i;
    wdata_d = wb_we_i ? wb_data_i : dbg_data_i;
  end

  // Entry 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
    end else if (we_d && (waddr_d != '0)) begin
      mem_q[waddr_d] <= wdata_d;
    end
  end

  assign rs_data_o     = mem_q[rs_addr_i];
  assign rt_data_o     = mem_q[rt_addr_i];
  assign dbg_rd_data_o = mem_q[dbg_rd_addr_i];

endmodule

// File: rtl/alu_issue.sv
// Single-issue front end for an external registered ALU: IDLE -> ISSUE -> WB.
// Optional immediate operand B is enabled by defining ALU_ISSUE_IMM_EN.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              InstrValid,
  output logic              InstrReady,
  input  logic [XLEN-1:0]   Instr,
  output logic [XLEN-1:0]   DataA,
  output logic [XLEN-1:0]   DataB,
  output logic [OP_W-1:0]   OPCode,
  input  logic [XLEN-1:0]   ResultC,
  input  logic [3:0]        Status,
  output logic [3:0]        Flags,
  output logic              Done,
  output logic              Illegal,
  input  logic              DbgWrEn,
  input  logic [REG_AW-1:0] DbgWrAddr,
  input  logic [XLEN-1:0]   DbgWrData,
  input  logic [REG_AW-1:0] DbgRdAddr,
  output logic [XLEN-1:0]   DbgRdData
);

  state_e            state_q;
  logic              ready_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   data_a_q;
  logic [XLEN-1:0]   data_b_q;
  logic [OP_W-1:0]   opcode_q;
  logic [3:0]        flags_q;
  logic              done_q;
  logic              illegal_q;

  logic [XLEN-1:0]   rs_data;
  logic [XLEN-1:0]   rt_data;
  logic [XLEN-1:0]   opb_d;
  logic              wb_we;
  logic              dbg_we;

  assign wb_we  = (state_q == ST_WB) && op_supported(opcode_q);
  assign dbg_we = DbgWrEn && (state_q == ST_IDLE);

  alu_issue_regfile u_regfile (
    .clk_i         (Clock),
    .rst_i         (Reset),
    .dbg_we_i      (dbg_we),
    .dbg_addr_i    (DbgWrAddr),
    .dbg_data_i    (DbgWrData),
    .wb_we_i       (wb_we),
    .wb_addr_i     (rd_q),
    .wb_data_i     (ResultC),
    .rs_addr_i     (Instr[RS_HI:RS_LO]),
    .rs_data_o     (rs_data),
    .rt_addr_i     (Instr[RT_HI:RT_LO]),
    .rt_data_o     (rt_data),
    .dbg_rd_addr_i (DbgRdAddr),
    .dbg_rd_data_o (DbgRdData)
  );

`ifdef ALU_ISSUE_IMM_EN
  logic unused_status;
  assign unused_status = Status[1];

  always_comb begin
    opb_d = rt_data;
    if (Instr[IMM_BIT]) begin
      opb_d = {{(XLEN-IMM_W){1'b0}}, Instr[IMM_W-1:0]};
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{Status[1], Instr[IMM_BIT], Instr[IMM_W-1:0]};

  always_comb begin
    opb_d = rt_data;
  end
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      rd_q      <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      opcode_q  <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (InstrValid && ready_q) begin
            data_a_q <= rs_data;
            data_b_q <= opb_d;
            opcode_q <= Instr[OP_HI:OP_LO];
            rd_q     <= Instr[RD_HI:RD_LO];
            ready_q  <= 1'b0;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WB;
        end
        ST_WB: begin
          done_q    <= 1'b1;
          illegal_q <= !op_supported(opcode_q);
          // Zero flag is architecturally dropped; only ADD touches the flags.
          if (opcode_q == OP_ADD) begin
            flags_q <= {Status[3], Status[2], 1'b0, Status[0]};
          end
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign InstrReady = ready_q;
  assign DataA      = data_a_q;
  assign DataB      = data_b_q;
  assign OPCode     = opcode_q;
  assign Flags      = flags_q;
  assign Done       = done_q;
  assign Illegal    = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: registered ALU stand-in, per-cycle reference
// model compare, and directed vectors with literal expectations.
module tb_alu_issue;

  localparam logic [5:0] T_ADD = 6'b010000;
  localparam logic [5:0] T_OR  = 6'b010001;
  localparam logic [5:0] T_NOR = 6'b010010;
  localparam logic [5:0] T_XOR = 6'b010011;
  localparam logic [5:0] T_RLS = 6'b001100;
  localparam logic [5:0] T_LLS = 6'b001101;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic [31:0] DataA, DataB;
  logic [5:0]  OPCode;
  logic [31:0] ResultC;
  logic [3:0]  Status;
  logic [3:0]  Flags;
  logic        Done, Illegal;
  logic        DbgWrEn;
  logic [4:0]  DbgWrAddr;
  logic [31:0] DbgWrData;
  logic [4:0]  DbgRdAddr;
  logic [31:0] DbgRdData;

  int unsigned total = 0;
  int unsigned bad   = 0;

  alu_issue dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .Instr      (Instr),
    .DataA      (DataA),
    .DataB      (DataB),
    .OPCode     (OPCode),
    .ResultC    (ResultC),
    .Status     (Status),
    .Flags      (Flags),
    .Done       (Done),
    .Illegal    (Illegal),
    .DbgWrEn    (DbgWrEn),
    .DbgWrAddr  (DbgWrAddr),
    .DbgWrData  (DbgWrData),
    .DbgRdAddr  (DbgRdAddr),
    .DbgRdData  (DbgRdData)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ALU behaviour: {Over, Carry, Zero, Neg, result}
  function automatic logic [35:0] alu_f(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        ov, cy;
    ov = 1'b0;
    cy = 1'b0;
    s  = '0;
    case (op)
      T_ADD: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[31:0];
        cy = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      T_OR:    r = a | b;
      T_NOR:   r = ~(a | b);
      T_XOR:   r = a ^ b;
      T_RLS:   r = a >> b[4:0];
      T_LLS:   r = a << b[4:0];
      default: r = 32'hDEAD_BEEF;
    endcase
    return {ov, cy, (r == 32'd0), r[31], r};
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return (op == T_ADD) || (op == T_OR) || (op == T_NOR) || (op == T_XOR) ||
           (op == T_RLS) || (op == T_LLS);
  endfunction

  always @(posedge Clock) {Status, ResultC} <= alu_f(OPCode, DataA, DataB);

  // Reference model: architectural registers, flags, and the in-flight instruction.
  logic [31:0] m_reg [32];
  logic [3:0]  m_flags;
  int          m_stage;
  logic [5:0]  rec_op;
  logic [4:0]  rec_rd;
  logic [31:0] rec_a, rec_b;

  initial begin
    logic [35:0] ar;
    m_stage = 0;
    m_flags = '0;
    foreach (m_reg[i]) m_reg[i] = '0;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        chk("rst_done",    Done, 0);
        chk("rst_illegal", Illegal, 0);
        chk("rst_flags",   Flags, 0);
        chk("rst_dataa",   DataA, 0);
        chk("rst_datab",   DataB, 0);
        chk("rst_opcode",  OPCode, 0);
        chk("rst_ready",   InstrReady, 1);
        foreach (m_reg[i]) m_reg[i] = '0;
        m_flags = '0;
        m_stage = 0;
      end else begin
        chk("ready",   InstrReady, (m_stage == 0) || (m_stage == 3));
        chk("done",    Done, m_stage == 3);
        chk("illegal", Illegal, (m_stage == 3) && !legal(rec_op));
        chk("flags",   Flags, m_flags);
        chk("dbgrd",   DbgRdData, m_reg[DbgRdAddr]);
        if (m_stage == 1 || m_stage == 2) begin
          chk("dataa",  DataA, rec_a);
          chk("datab",  DataB, rec_b);
          chk("opcode", OPCode, rec_op);
        end
        case (m_stage)
          1: m_stage = 2;
          2: begin
            ar = alu_f(rec_op, rec_a, rec_b);
            if (legal(rec_op)) begin
              if (rec_rd != 0) m_reg[rec_rd] = ar[31:0];
              if (rec_op == T_ADD) m_flags = {ar[35], ar[34], 1'b0, ar[32]};
            end
            m_stage = 3;
          end
          default: begin
            m_stage = 0;
            if (InstrValid) begin
              rec_op = Instr[31:26];
              rec_rd = Instr[25:21];
              rec_a  = m_reg[Instr[20:16]];
              rec_b  = m_reg[Instr[15:11]];
`ifdef ALU_ISSUE_IMM_EN
              if (Instr[10]) rec_b = {22'd0, Instr[9:0]};
`endif
              m_stage = 1;
            end
            if (DbgWrEn && DbgWrAddr != 0) m_reg[DbgWrAddr] = DbgWrData;
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic dbg_wr(input logic [4:0] a, input logic [31:0] d);
    DbgWrEn   = 1'b1;
    DbgWrAddr = a;
    DbgWrData = d;
    tick();
    DbgWrEn   = 1'b0;
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [10:0] low);
    int n;
    n = 0;
    while (!InstrReady && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: ready=%0b expected 1 within 20 cycles", InstrReady);
    end
    InstrValid = 1'b1;
    Instr      = {op, rd, rs, rt, low};
    tick();
    InstrValid = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
    DbgRdAddr = a;
    #1;
    chk(nm, DbgRdData, exp);
  endtask

  initial begin
    Reset      = 1'b1;
    InstrValid = 1'b0;
    Instr      = '0;
    DbgWrEn    = 1'b0;
    DbgWrAddr  = '0;
    DbgWrData  = '0;
    DbgRdAddr  = '0;
    repeat (3) tick();
    Reset = 1'b0;
    chk("ready_after_reset", InstrReady, 1);

    // 5 + 7 into R3, Done exactly 3 cycles after acceptance
    dbg_wr(5'd1, 32'd5);
    dbg_wr(5'd2, 32'd7);
    issue(T_ADD, 5'd3, 5'd1, 5'd2, 11'd0);
    chk("lat_nodone", Done, 0);
    tick();
    chk("lat_nodone2", Done, 0);
    tick();
    chk("lat_done", Done, 1);
    chk("lat_illegal", Illegal, 0);
    chk("add_flags", Flags, 4'b0000);
    rd_chk("add_r3", 5'd3, 32'd12);
    tick();

    // Signed overflow into the sign bit
    dbg_wr(5'd1, 32'h7FFF_FFFF);
    dbg_wr(5'd2, 32'd1);
    issue(T_ADD, 5'd4, 5'd1, 5'd2, 11'd0);
    repeat (2) tick();
    rd_chk("ovf_r4", 5'd4, 32'h8000_0000);
    chk("ovf_flags", Flags, 4'b1001);

    // Unsupported opcode: no write, flags held
    issue(6'b111111, 5'd5, 5'd1, 5'd2, 11'd0);
    repeat (2) tick();
    chk("ill_done", Done, 1);
    chk("ill_illegal", Illegal, 1);
    chk("ill_flags", Flags, 4'b1001);
    rd_chk("ill_r5", 5'd5, 32'd0);

    // Logic and shift ops, flags untouched by non-ADD
    dbg_wr(5'd6, 32'hF0F0_1234);
    dbg_wr(5'd7, 32'd4);
    issue(T_OR,  5'd8,  5'd6, 5'd7, 11'd0);
    issue(T_NOR, 5'd9,  5'd6, 5'd7, 11'd0);
    issue(T_XOR, 5'd10, 5'd6, 5'd7, 11'd0);
    issue(T_RLS, 5'd11, 5'd6, 5'd7, 11'd0);
    issue(T_LLS, 5'd12, 5'd6, 5'd7, 11'd0);
    repeat (3) tick();
    rd_chk("nor_r9",  5'd9,  32'h0F0F_EDCB);
    rd_chk("rls_r11", 5'd11, 32'h0F0F_0123);
    rd_chk("lls_r12", 5'd12, 32'h0F01_2340);
    chk("logic_flags", Flags, 4'b1001);

    // Back-to-back dependent instructions need no forwarding
    issue(T_ADD, 5'd13, 5'd3, 5'd3, 11'd0);
    issue(T_XOR, 5'd14, 5'd13, 5'd3, 11'd0);
    repeat (3) tick();
    rd_chk("dep_r14", 5'd14, 32'h0000_0014);

    // R0 stays zero
    issue(T_XOR, 5'd0, 5'd6, 5'd7, 11'd0);
    repeat (3) tick();
    rd_chk("r0_zero", 5'd0, 32'd0);

    // Debug write while busy is dropped
    issue(T_OR, 5'd15, 5'd6, 5'd7, 11'd0);
    DbgWrEn   = 1'b1;
    DbgWrAddr = 5'd20;
    DbgWrData = 32'h0000_ABCD;
    repeat (2) tick();
    DbgWrEn = 1'b0;
    tick();
    rd_chk("busy_dbg_r20", 5'd20, 32'd0);

    // Debug write coinciding with acceptance: operands see the old value
    DbgWrEn    = 1'b1;
    DbgWrAddr  = 5'd6;
    DbgWrData  = 32'd1;
    InstrValid = 1'b1;
    Instr      = {T_XOR, 5'd16, 5'd6, 5'd7, 11'd0};
    tick();
    DbgWrEn    = 1'b0;
    InstrValid = 1'b0;
    repeat (3) tick();
    rd_chk("coinc_r16", 5'd16, 32'hF0F0_1230);
    rd_chk("coinc_r6",  5'd6,  32'd1);

    // Immediate operand select
    dbg_wr(5'd1, 32'h0000_00F0);
    dbg_wr(5'd2, 32'h0000_0300);
    issue(T_OR, 5'd18, 5'd1, 5'd2, {1'b1, 10'h00F});
    repeat (3) tick();
`ifdef ALU_ISSUE_IMM_EN
    rd_chk("imm_r18", 5'd18, 32'h0000_00FF);
`else
    rd_chk("noimm_r18", 5'd18, 32'h0000_03F0);
`endif

    // Reset during ISSUE discards the in-flight ADD
    issue(T_ADD, 5'd17, 5'd1, 5'd2, 11'd0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("midrst_ready", InstrReady, 1);
    for (int i = 0; i < 4; i++) begin
      chk("midrst_nodone", Done, 0);
      tick();
    end
    rd_chk("midrst_r17", 5'd17, 32'd0);
    rd_chk("midrst_r3",  5'd3,  32'd0);
    chk("midrst_flags", Flags, 4'b0000);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
